multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_decode.sv | 78 +++++++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcode/func constants, ALU operation codes and the decode bundle.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   // Where EX goes next
   typedef enum logic [1:0] {
      CL_BRJ   = 2'd0,
      CL_LOAD  = 2'd1,
      CL_STORE = 2'd2,
      CL_WB    = 2'd3
   } cls_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001,
                          OP_J     = 6'b000010, OP_JAL    = 6'b000011,
                          OP_BEQ   = 6'b000100, OP_BNE    = 6'b000101,
                          OP_BLEZ  = 6'b000110, OP_BGTZ   = 6'b000111,
                          OP_ADDIU = 6'b001001, OP_SLTI   = 6'b001010,
                          OP_SLTIU = 6'b001011, OP_ANDI   = 6'b001100,
                          OP_ORI   = 6'b001101, OP_XORI   = 6'b001110,
                          OP_LUI   = 6'b001111, OP_LB     = 6'b100000,
                          OP_LW    = 6'b100011, OP_LBU    = 6'b100100,
                          OP_SB    = 6'b101000, OP_SW     = 6'b101011;

   localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011,
                          F_SLT  = 6'b101010, F_AND  = 6'b100100,
                          F_NOR  = 6'b100111, F_OR   = 6'b100101,
                          F_XOR  = 6'b100110, F_SLL  = 6'b000000,
                          F_SRL  = 6'b000010, F_SLTU = 6'b101011,
                          F_JALR = 6'b001001, F_JR   = 6'b001000,
                          F_SLLV = 6'b000100, F_SRA  = 6'b000011,
                          F_SRAV = 6'b000111, F_SRLV = 6'b000110;

   localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

   localparam logic [4:0] ALU_ADDU = 5'd0,  ALU_SUBU = 5'd1,  ALU_SLT  = 5'd2,
                          ALU_AND  = 5'd3,  ALU_NOR  = 5'd4,  ALU_OR   = 5'd5,
                          ALU_XOR  = 5'd6,  ALU_SLL  = 5'd7,  ALU_SRL  = 5'd8,
                          ALU_SLTU = 5'd9,  ALU_LINK = 5'd10, ALU_JR   = 5'd11,
                          ALU_SLLV = 5'd12, ALU_SRA  = 5'd13, ALU_SRAV = 5'd14,
                          ALU_SRLV = 5'd15, ALU_LUI  = 5'd16;

   // branch = {beq,bne,bgez,bgtz,blez,bltz}, j = {jump,jal,jr,jalr}
   typedef struct packed {
      logic       illegal;
      cls_e       cls;
      logic [5:0] branch;
      logic [3:0] j;
      logic       link;
      logic       load;
      logic       lb;
      logic       lbu;
      logic       sb;
      logic       use_shamt;
      logic       reg_dst;
      logic       ext_op;
      logic       alu_src;
      logic       rtype;
      logic [4:0] alu;
   } dec_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure combinational instruction decode: op/func/rt to static controls,
// instruction class and legality.
module ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic [4:0] rt,
   output dec_t       dec
);

   always_comb begin
      dec     = '0;
      dec.cls = CL_WB;
      case (op)
         OP_RTYPE: begin
            dec.rtype   = 1'b1;
            dec.reg_dst = 1'b1;
            case (func)
               F_ADDU: dec.alu = ALU_ADDU;
               F_SUBU: dec.alu = ALU_SUBU;
               F_SLT:  dec.alu = ALU_SLT;
               F_AND:  dec.alu = ALU_AND;
               F_NOR:  dec.alu = ALU_NOR;
               F_OR:   dec.alu = ALU_OR;
               F_XOR:  dec.alu = ALU_XOR;
               F_SLL:  begin dec.alu = ALU_SLL; dec.use_shamt = 1'b1; end
               F_SRL:  begin dec.alu = ALU_SRL; dec.use_shamt = 1'b1; end
               F_SRA:  begin dec.alu = ALU_SRA; dec.use_shamt = 1'b1; end
               F_SLTU: dec.alu = ALU_SLTU;
               F_SLLV: dec.alu = ALU_SLLV;
               F_SRAV: dec.alu = ALU_SRAV;
               F_SRLV: dec.alu = ALU_SRLV;
               F_JALR: begin dec.alu = ALU_LINK; dec.j[0] = 1'b1; dec.link = 1'b1; end
               F_JR:   begin dec.alu = ALU_JR; dec.j[1] = 1'b1; dec.cls = CL_BRJ; end
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            dec.alu    = ALU_SUBU;
            dec.ext_op = 1'b1;
            dec.cls    = CL_BRJ;
            if (rt == RT_BGEZ)      dec.branch[3] = 1'b1;
            else if (rt == RT_BLTZ) dec.branch[0] = 1'b1;
            else                    dec.illegal   = 1'b1;
         end
         OP_BEQ:  begin dec.branch[5] = 1'b1; dec.alu = ALU_SUBU; dec.ext_op = 1'b1; dec.cls = CL_BRJ; end
         OP_BNE:  begin dec.branch[4] = 1'b1; dec.alu = ALU_SUBU; dec.ext_op = 1'b1; dec.cls = CL_BRJ; end
         OP_BGTZ: begin dec.branch[2] = 1'b1; dec.alu = ALU_SUBU; dec.ext_op = 1'b1; dec.cls = CL_BRJ; end
         OP_BLEZ: begin dec.branch[1] = 1'b1; dec.alu = ALU_SUBU; dec.ext_op = 1'b1; dec.cls = CL_BRJ; end
         OP_J:    begin dec.j[3] = 1'b1; dec.cls = CL_BRJ; end
         OP_JAL:  begin dec.j[2] = 1'b1; dec.link = 1'b1; dec.alu = ALU_LINK; end
         OP_ADDIU: begin dec.alu = ALU_ADDU; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
         OP_SLTI:  begin dec.alu = ALU_SLT;  dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
         OP_SLTIU: begin dec.alu = ALU_SLTU; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
         OP_ANDI:  begin dec.alu = ALU_AND;  dec.alu_src = 1'b1; end
         OP_ORI:   begin dec.alu = ALU_OR;   dec.alu_src = 1'b1; end
         OP_XORI:  begin dec.alu = ALU_XOR;  dec.alu_src = 1'b1; end
         OP_LUI:   begin dec.alu = ALU_LUI;  dec.alu_src = 1'b1; end
         OP_LW, OP_LB, OP_LBU: begin
            dec.alu_src = 1'b1;
            dec.ext_op  = 1'b1;
            dec.load    = 1'b1;
            dec.lb      = (op == OP_LB);
            dec.lbu     = (op == OP_LBU);
            dec.cls     = CL_LOAD;
         end
         OP_SW, OP_SB: begin
            dec.alu_src = 1'b1;
            dec.ext_op  = 1'b1;
            dec.sb      = (op == OP_SB);
            dec.cls     = CL_STORE;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM (IF/ID/EX/MEM/WB) with memory-wait timeout.
// Decode fields are captured in ID; later states decode only the captured copy.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int ALUCTR_W = 5,
   parameter int WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   input  logic [4:0]          rt,
   input  logic                mem_ready,
   output logic                pc_wr,
   output logic                ir_wr,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic [5:0]          branch,
   output logic [3:0]          j,
   output logic                link,
   output logic                lb,
   output logic                lbu,
   output logic                sb,
   output logic                use_shamt,
   output logic                reg_dst,
   output logic                mem2reg,
   output logic                reg_wr,
   output logic                ext_op,
   output logic                alu_src,
   output logic                rtype,
   output logic [ALUCTR_W-1:0] alu_ctr,
   output logic [2:0]          state,
   output logic                illegal,
   output logic                mem_err
);

   if (ALUCTR_W < 5) begin : g_bad_aluctr_w
      $error("multicycle_ctrl: ALUCTR_W must be at least 5");
   end
   if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
      $error("multicycle_ctrl: WAIT_MAX must be in 1..255");
   end

   state_e     state_q, state_d;
   logic       mem_rd_q, mem_rd_d;
   logic       mem_wr_q, mem_wr_d;
   logic [7:0] wait_q, wait_d;
   logic [5:0] op_q, op_d, func_q, func_d;
   logic [4:0] rt_q, rt_d;

   logic [5:0] dec_op, dec_func;
   logic [4:0] dec_rt;
   dec_t       dec;
   logic       timeout, exe;

   // ID decodes the live instruction for the legality check; later states use the capture
   assign dec_op   = (state_q == S_ID) ? op   : op_q;
   assign dec_func = (state_q == S_ID) ? func : func_q;
   assign dec_rt   = (state_q == S_ID) ? rt   : rt_q;

   ctrl_decode u_dec (
      .op   (dec_op),
      .func (dec_func),
      .rt   (dec_rt),
      .dec  (dec)
   );

   // Last permitted non-ready cycle; a ready in the same cycle takes priority
   assign timeout = (mem_rd_q || mem_wr_q) && !mem_ready && (wait_q == 8'(WAIT_MAX - 1));

   always_comb begin
      state_d  = state_q;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      wait_d   = wait_q;
      op_d     = op_q;
      func_d   = func_q;
      rt_d     = rt_q;
      case (state_q)
         S_IF: begin
            if (!mem_rd_q)      mem_rd_d = 1'b1;
            else if (mem_ready) state_d  = S_ID;
            else if (!timeout) begin
               mem_rd_d = 1'b1;
               wait_d   = wait_q + 8'd1;
            end else            wait_d   = '0;
         end
         S_ID: begin
            op_d   = op;
            func_d = func;
            rt_d   = rt;
            if (dec.illegal) begin
               state_d  = S_IF;
               mem_rd_d = 1'b1;
               wait_d   = '0;
            end else state_d = S_EX;
         end
         S_EX: begin
            case (dec.cls)
               CL_LOAD:  begin state_d = S_MEM; mem_rd_d = 1'b1; wait_d = '0; end
               CL_STORE: begin state_d = S_MEM; mem_wr_d = 1'b1; wait_d = '0; end
               CL_WB:    state_d = S_WB;
               default:  begin state_d = S_IF; mem_rd_d = 1'b1; wait_d = '0; end
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (mem_wr_q) begin
                  state_d  = S_IF;
                  mem_rd_d = 1'b1;
                  wait_d   = '0;
               end else state_d = S_WB;
            end else if (timeout) begin
               state_d = S_IF;
               wait_d  = '0;
            end else begin
               mem_rd_d = mem_rd_q;
               mem_wr_d = mem_wr_q;
               wait_d   = wait_q + 8'd1;
            end
         end
         S_WB: begin
            state_d  = S_IF;
            mem_rd_d = 1'b1;
            wait_d   = '0;
         end
         default: begin
            state_d = S_IF;
            wait_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IF;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         wait_q   <= '0;
         op_q     <= '0;
         func_q   <= '0;
         rt_q     <= '0;
      end else begin
         state_q  <= state_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         wait_q   <= wait_d;
         op_q     <= op_d;
         func_q   <= func_d;
         rt_q     <= rt_d;
      end
   end

   assign exe = (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB);

   assign state     = state_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign ir_wr     = (state_q == S_IF) && mem_rd_q && mem_ready;
   assign pc_wr     = (state_q == S_IF) && mem_rd_q && mem_ready;
   assign illegal   = (state_q == S_ID) && dec.illegal;
   assign mem_err   = timeout;
   assign branch    = (state_q == S_EX) ? dec.branch : 6'd0;
   assign j         = (state_q == S_EX) ? dec.j : 4'd0;
   assign reg_wr    = (state_q == S_WB);
   assign link      = (state_q == S_WB) && dec.link;
   assign mem2reg   = (state_q == S_WB) && dec.load;
   assign lb        = exe && dec.lb;
   assign lbu       = exe && dec.lbu;
   assign sb        = exe && dec.sb;
   assign use_shamt = exe && dec.use_shamt;
   assign reg_dst   = exe && dec.reg_dst;
   assign ext_op    = exe && dec.ext_op;
   assign alu_src   = exe && dec.alu_src;
   assign rtype     = exe && dec.rtype;
   assign alu_ctr   = exe ? ALUCTR_W'(dec.alu) : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction procedural model
// driven from an instruction table predicts every output on every cycle.
module tb_multicycle_ctrl;

  localparam int WMAX = 3;
  localparam int AW   = 6;
  localparam logic [1:0] C_BRJ = 2'd0, C_LD = 2'd1, C_ST = 2'd2, C_WB = 2'd3;

  logic clk, rst_n, mem_ready;
  logic [5:0] op, func;
  logic [4:0] rt;
  logic pc_wr, ir_wr, mem_rd, mem_wr, link, lb, lbu, sb, use_shamt, reg_dst;
  logic mem2reg, reg_wr, ext_op, alu_src, rtype, illegal, mem_err;
  logic [5:0] branch;
  logic [3:0] j;
  logic [AW-1:0] alu_ctr;
  logic [2:0] state;

  multicycle_ctrl #(.ALUCTR_W(AW), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .rt(rt), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch),
    .j(j), .link(link), .lb(lb), .lbu(lbu), .sb(sb), .use_shamt(use_shamt),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_wr(reg_wr), .ext_op(ext_op),
    .alu_src(alu_src), .rtype(rtype), .alu_ctr(alu_ctr), .state(state),
    .illegal(illegal), .mem_err(mem_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op, sub;
    logic [1:0] cls;
    logic [4:0] alu;
    logic [5:0] br;
    logic [3:0] jj;
    logic src, ext, sh;
  } ent_t;

  typedef struct packed {
    logic [2:0] st;
    logic rd, wr, irw, pcw, regw, ill, merr, lnk, m2r;
    logic [5:0] br;
    logic [3:0] jj;
    logic lb, lbu, sb, sh, rdst, ext, src, rty;
    logic [5:0] alu;
  } exp_t;

  ent_t tbl[$];
  int   n_cmp = 0, n_bad = 0, n_ins = 0;
  bit   fetch_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s instr=%0d got=%h exp=%h", tag, n_ins, got, exp);
    end
  endtask

  task automatic cmp(input exp_t x, input string tag);
    chk({tag, ".ctl"},
        32'({state, mem_rd, mem_wr, ir_wr, pc_wr, reg_wr, illegal, mem_err, link, mem2reg, branch, j}),
        32'({x.st, x.rd, x.wr, x.irw, x.pcw, x.regw, x.ill, x.merr, x.lnk, x.m2r, x.br, x.jj}));
    chk({tag, ".dec"},
        32'({lb, lbu, sb, use_shamt, reg_dst, ext_op, alu_src, rtype, alu_ctr}),
        32'({x.lb, x.lbu, x.sb, x.sh, x.rdst, x.ext, x.src, x.rty, x.alu}));
  endtask

  // called at posedge+1: drive ready, check mid-cycle, advance one clock
  task automatic step(input logic rdy, input exp_t x, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    cmp(x, tag);
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [5:0] o, s, input logic [1:0] c, input logic [4:0] a,
                              input logic [5:0] b, input logic [3:0] jv, input logic src, ext, sh);
    ent_t e;
    e = '{op: o, sub: s, cls: c, alu: a, br: b, jj: jv, src: src, ext: ext, sh: sh};
    return e;
  endfunction

  task automatic build_tbl();
    // R-type: sub = func
    tbl.push_back(mk(6'h00, 6'h21, C_WB, 0, 0, 0, 0, 0, 0));  tbl.push_back(mk(6'h00, 6'h23, C_WB, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h2A, C_WB, 2, 0, 0, 0, 0, 0));  tbl.push_back(mk(6'h00, 6'h24, C_WB, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h27, C_WB, 4, 0, 0, 0, 0, 0));  tbl.push_back(mk(6'h00, 6'h25, C_WB, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h26, C_WB, 6, 0, 0, 0, 0, 0));  tbl.push_back(mk(6'h00, 6'h00, C_WB, 7, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h00, 6'h02, C_WB, 8, 0, 0, 0, 0, 1));  tbl.push_back(mk(6'h00, 6'h2B, C_WB, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h09, C_WB, 10, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h08, C_BRJ, 11, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h04, C_WB, 12, 0, 0, 0, 0, 0)); tbl.push_back(mk(6'h00, 6'h03, C_WB, 13, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h00, 6'h07, C_WB, 14, 0, 0, 0, 0, 0)); tbl.push_back(mk(6'h00, 6'h06, C_WB, 15, 0, 0, 0, 0, 0));
    // REGIMM: sub = rt
    tbl.push_back(mk(6'h01, 6'h01, C_BRJ, 1, 6'b001000, 0, 0, 1, 0));
    tbl.push_back(mk(6'h01, 6'h00, C_BRJ, 1, 6'b000001, 0, 0, 1, 0));
    // remaining opcodes: sub ignored
    tbl.push_back(mk(6'h04, 0, C_BRJ, 1, 6'b100000, 0, 0, 1, 0)); tbl.push_back(mk(6'h05, 0, C_BRJ, 1, 6'b010000, 0, 0, 1, 0));
    tbl.push_back(mk(6'h06, 0, C_BRJ, 1, 6'b000010, 0, 0, 1, 0)); tbl.push_back(mk(6'h07, 0, C_BRJ, 1, 6'b000100, 0, 0, 1, 0));
    tbl.push_back(mk(6'h02, 0, C_BRJ, 0, 0, 4'b1000, 0, 0, 0));   tbl.push_back(mk(6'h03, 0, C_WB, 10, 0, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(6'h09, 0, C_WB, 0, 0, 0, 1, 1, 0));  tbl.push_back(mk(6'h0A, 0, C_WB, 2, 0, 0, 1, 1, 0));
    tbl.push_back(mk(6'h0B, 0, C_WB, 9, 0, 0, 1, 1, 0));  tbl.push_back(mk(6'h0C, 0, C_WB, 3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(6'h0D, 0, C_WB, 5, 0, 0, 1, 0, 0));  tbl.push_back(mk(6'h0E, 0, C_WB, 6, 0, 0, 1, 0, 0));
    tbl.push_back(mk(6'h0F, 0, C_WB, 16, 0, 0, 1, 0, 0));
    tbl.push_back(mk(6'h23, 0, C_LD, 0, 0, 0, 1, 1, 0));  tbl.push_back(mk(6'h20, 0, C_LD, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(6'h24, 0, C_LD, 0, 0, 0, 1, 1, 0));  tbl.push_back(mk(6'h2B, 0, C_ST, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(6'h28, 0, C_ST, 0, 0, 0, 1, 1, 0));
  endtask

  function automatic bit lookup(input logic [5:0] o, f, input logic [4:0] r, output ent_t e);
    e = '0;
    foreach (tbl[i]) begin
      if (tbl[i].op == o &&
          ((o == 6'h00) ? (tbl[i].sub == f) : (o == 6'h01) ? (tbl[i].sub == {1'b0, r}) : 1'b1)) begin
        e = tbl[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic exp_t statics(input ent_t e);
    exp_t s;
    s = '0;
    s.lb   = (e.op == 6'h20);
    s.lbu  = (e.op == 6'h24);
    s.sb   = (e.op == 6'h28);
    s.sh   = e.sh;
    s.rdst = (e.op == 6'h00);
    s.rty  = (e.op == 6'h00);
    s.ext  = e.ext;
    s.src  = e.src;
    s.alu  = {1'b0, e.alu};
    return s;
  endfunction

  task automatic scramble();
    op = 6'($urandom); func = 6'($urandom); rt = 5'($urandom);
  endtask

  // One instruction; ifw/memw = non-ready cycles before ready in IF / MEM.
  task automatic run_instr(input logic [5:0] o, f, input logic [4:0] r,
                           input int ifw, input int memw, input bit rst_mem);
    ent_t e;
    bit   ok;
    exp_t x, s;
    n_ins++;
    ok = lookup(o, f, r, e);
    if (fetch_idle) begin
      x = '0;
      step(1'($urandom), x, "IFidle");
      fetch_idle = 1'b0;
    end
    for (int k = 0; k < ifw; k++) begin
      x = '0; x.rd = 1'b1;
      if (k == WMAX - 1) begin
        x.merr = 1'b1;
        step(1'b0, x, "IFtmo");
        fetch_idle = 1'b1;
        return;
      end
      step(1'b0, x, "IFwait");
    end
    x = '0; x.rd = 1'b1; x.irw = 1'b1; x.pcw = 1'b1;
    step(1'b1, x, "IF");
    op = o; func = f; rt = r;
    x = '0; x.st = 3'd1; x.ill = !ok;
    step(1'($urandom), x, "ID");
    scramble();
    if (!ok) return;
    s = statics(e);
    x = s; x.st = 3'd2; x.br = e.br; x.jj = e.jj;
    step(1'($urandom), x, "EX");
    if (e.cls == C_BRJ) return;
    if (e.cls == C_LD || e.cls == C_ST) begin
      for (int k = 0; k <= memw; k++) begin
        x = s; x.st = 3'd3; x.rd = (e.cls == C_LD); x.wr = (e.cls == C_ST);
        if (rst_mem) begin
          cmp(x, "MEMpre");
          #2 rst_n = 1'b0;
          #1 cmp('0, "RSTasync");
          @(posedge clk);
          #1 rst_n = 1'b1;
          fetch_idle = 1'b1;
          return;
        end
        if (k == memw) begin
          step(1'b1, x, "MEM");
          break;
        end
        if (k == WMAX - 1) begin
          x.merr = 1'b1;
          step(1'b0, x, "MEMtmo");
          fetch_idle = 1'b1;
          return;
        end
        step(1'b0, x, "MEMwait");
      end
      if (e.cls == C_ST) return;
    end
    x = s; x.st = 3'd4; x.regw = 1'b1; x.lnk = e.jj[2] | e.jj[0]; x.m2r = (e.cls == C_LD);
    step(1'($urandom), x, "WB");
  endtask

  function automatic int pick_w();
    return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
  endfunction

  initial begin
    logic [5:0] o, f;
    logic [4:0] r;
    int k;
    build_tbl();
    rst_n = 1'b0; mem_ready = 1'b1; op = 6'h23; func = 6'h21; rt = 5'd1;
    @(negedge clk); cmp('0, "RST0");
    mem_ready = 1'b0;
    @(negedge clk); cmp('0, "RST1");
    @(posedge clk); #1 rst_n = 1'b1;
    fetch_idle = 1'b1;

    run_instr(6'h00, 6'h21, 5'd3, 0, 0, 0);   // addu
    run_instr(6'h23, 6'h15, 5'd7, 0, 2, 0);   // lw, two MEM waits (boundary: ready on last allowed cycle)
    run_instr(6'h01, 6'h2C, 5'd1, 0, 0, 0);   // bgez
    run_instr(6'h01, 6'h11, 5'd0, 0, 0, 0);   // bltz
    run_instr(6'h01, 6'h00, 5'd2, 0, 0, 0);   // regimm with bad rt
    run_instr(6'h00, 6'h21, 5'd0, 3, 0, 0);   // fetch timeout
    run_instr(6'h00, 6'h3F, 5'd0, 2, 0, 0);   // illegal func, fetch ready on last allowed cycle
    run_instr(6'h2B, 6'h00, 5'd0, 0, 3, 0);   // sw store timeout
    run_instr(6'h03, 6'h00, 5'd0, 0, 0, 0);   // jal
    run_instr(6'h2B, 6'h00, 5'd0, 0, 1, 1);   // sw aborted by reset in MEM
    run_instr(6'h28, 6'h00, 5'd0, 1, 0, 0);   // sb after reset

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        k = int'($urandom_range(0, tbl.size() - 1));
        o = tbl[k].op; f = 6'($urandom); r = 5'($urandom);
        if (o == 6'h00) f = tbl[k].sub;
        if (o == 6'h01) r = tbl[k].sub[4:0];
      end else begin
        o = 6'($urandom); f = 6'($urandom); r = 5'($urandom);
      end
      run_instr(o, f, r, pick_w(), pick_w(), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
